refmux_modulator: RTL and testbench

//  Parametrised successor to the fixed +/-ref test modulator. Drives the ref-current mux through

---
 rtl/refmux_modulator_pkg.sv | 40 ++++
 rtl/refmux_modulator_phase_counter.sv | 34 +++
 rtl/refmux_modulator.sv | 197 +++++++++++++++++++
 tb/tb_refmux_modulator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/refmux_modulator_pkg.sv
// ============================================================================
// Module : refmux_modulator_pkg
// Brief  : Shared refmux drive codes and modulator state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package refmux_modulator_pkg;

    localparam logic [2:0] REFMUX_NONE     = 3'b000;
    localparam logic [2:0] REFMUX_POS      = 3'b001;
    localparam logic [2:0] REFMUX_NEG      = 3'b010;
    localparam logic [2:0] REFMUX_SLOW_POS = 3'b011;
    localparam logic [2:0] REFMUX_RESET    = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET    = 3'd1,
        ST_FIX_POS  = 3'd2,
        ST_FIX_NEG  = 3'd3,
        ST_FIX_NONE = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    function automatic logic [2:0] refmux_of(input state_t s);
        case (s)
            ST_FIX_POS:  refmux_of = REFMUX_POS;
            ST_FIX_NEG:  refmux_of = REFMUX_NEG;
            ST_FIX_NONE: refmux_of = REFMUX_NONE;
            default:     refmux_of = REFMUX_RESET;
        endcase
    endfunction

    function automatic logic is_busy(input state_t s);
        is_busy = (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/refmux_modulator_phase_counter.sv
// ============================================================================
// Module : refmux_modulator_phase_counter
// Brief  : Loadable down-counter with zero flag; stops at zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module refmux_modulator_phase_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/refmux_modulator.sv
// ============================================================================
// Module : refmux_modulator
// Brief  : Reference-current mux sequencer: RESET, N x {POS,NEG[,NONE]}, DONE.
//          Optional REFMUX_MOD_CMPR_COUNT_EN adds cmpr_hi_cnt_o.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module refmux_modulator
    import refmux_modulator_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             mode3_i,
    input  logic [CNT_W-1:0] p_clk_count_reset_i,
    input  logic [CNT_W-1:0] p_clk_count_fix_i,
    input  logic [CNT_W-1:0] p_clk_count_none_i,
    input  logic [CYC_W-1:0] p_cycles_i,
    input  logic             cmpr_val_i,
    output logic [2:0]       refmux_o,
    output logic             sigmux_o,
    output logic             cmpr_latch_ctl_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CYC_W-1:0] cycle_cnt_o,
    output logic [7:0]       monitor_o
`ifdef REFMUX_MOD_CMPR_COUNT_EN
    ,
    output logic [CYC_W-1:0] cmpr_hi_cnt_o
`endif
);

    state_t           state_q, state_d;
    logic [2:0]       refmux_q;
    logic             latch_q, busy_q, done_q;
    logic [CYC_W-1:0] cyc_q, cyc_d, cyc_inc;
    logic             mode3_q;
    logic [CYC_W-1:0] pcyc_q;
    logic [CNT_W-1:0] fix_q, none_q;
    logic             load, capture, cycle_end, zero;
    logic [CNT_W-1:0] load_val;

    refmux_modulator_phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .zero_o     (zero)
    );

    assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        load      = 1'b0;
        load_val  = '0;
        capture   = 1'b0;
        cycle_end = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d  = ST_RESET;
                        load     = 1'b1;
                        load_val = p_clk_count_reset_i;
                        capture  = 1'b1;
                        cyc_d    = '0;
                    end
                end
                ST_RESET: begin
                    if (zero) begin
                        state_d  = ST_FIX_POS;
                        load     = 1'b1;
                        load_val = fix_q;
                    end
                end
                ST_FIX_POS: begin
                    if (zero) begin
                        state_d  = ST_FIX_NEG;
                        load     = 1'b1;
                        load_val = fix_q;
                    end
                end
                ST_FIX_NEG: begin
                    if (zero && mode3_q) begin
                        state_d  = ST_FIX_NONE;
                        load     = 1'b1;
                        load_val = none_q;
                    end else if (zero) begin
                        cycle_end = 1'b1;
                    end
                end
                ST_FIX_NONE: begin
                    cycle_end = zero;
                end
                default: state_d = ST_IDLE;
            endcase
            // A finished cycle either terminates the run or restarts at POS on the same edge.
            if (cycle_end) begin
                cyc_d = cyc_inc;
                if ((pcyc_q != '0) && (cyc_inc == pcyc_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_FIX_POS;
                    load     = 1'b1;
                    load_val = fix_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            refmux_q <= REFMUX_RESET;
            latch_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cyc_q    <= '0;
            mode3_q  <= 1'b0;
            pcyc_q   <= '0;
            fix_q    <= '0;
            none_q   <= '0;
        end else begin
            state_q  <= state_d;
            refmux_q <= refmux_of(state_d);
            latch_q  <= !((state_d == ST_FIX_POS) || (state_d == ST_FIX_NEG) ||
                          (state_d == ST_FIX_NONE));
            busy_q   <= is_busy(state_d);
            done_q   <= (state_d == ST_DONE);
            cyc_q    <= cyc_d;
            if (capture) begin
                mode3_q <= mode3_i;
                pcyc_q  <= p_cycles_i;
                fix_q   <= p_clk_count_fix_i;
                none_q  <= p_clk_count_none_i;
            end
        end
    end

    logic cmpr_sync;

`ifdef REFMUX_MOD_CMPR_COUNT_EN
    logic             cmpr_s1_q, cmpr_s2_q;
    logic [CYC_W-1:0] hi_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cmpr_s1_q <= 1'b0;
            cmpr_s2_q <= 1'b0;
            hi_cnt_q  <= '0;
        end else begin
            cmpr_s1_q <= cmpr_val_i;
            cmpr_s2_q <= cmpr_s1_q;
            if (capture) begin
                hi_cnt_q <= '0;
            end else if ((state_q == ST_FIX_NEG) && zero && cmpr_s2_q && (hi_cnt_q != '1)) begin
                hi_cnt_q <= hi_cnt_q + CYC_W'(1);
            end
        end
    end

    assign cmpr_sync     = cmpr_s2_q;
    assign cmpr_hi_cnt_o = hi_cnt_q;
`else
    assign cmpr_sync = 1'b0;
`endif

    always_comb begin
        monitor_o    = '0;
        monitor_o[0] = (state_q == ST_FIX_POS);
        monitor_o[1] = (state_q == ST_FIX_NEG);
        monitor_o[2] = (state_q == ST_FIX_NONE);
        monitor_o[3] = cmpr_val_i;
        monitor_o[4] = is_busy(state_q);
        monitor_o[5] = (state_q == ST_DONE);
        monitor_o[6] = cmpr_sync;
    end

    assign refmux_o         = refmux_q;
    assign sigmux_o         = 1'b0;
    assign cmpr_latch_ctl_o = latch_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign cycle_cnt_o      = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_refmux_modulator.sv
// ============================================================================
// Module : tb_refmux_modulator
// Brief  : Scoreboard bench: stimulus pushes per-clock expectations, a negedge
//          monitor pops and compares.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_refmux_modulator;

    localparam int CNT_W = 32;
    localparam int CYC_W = 16;
    localparam logic [2:0] R_NONE  = 3'b000;
    localparam logic [2:0] R_POS   = 3'b001;
    localparam logic [2:0] R_NEG   = 3'b010;
    localparam logic [2:0] R_RESET = 3'b100;

    logic             clk = 1'b0;
    logic             reset, start_i, abort_i, mode3_i, cmpr_val_i;
    logic [CNT_W-1:0] p_reset, p_fix, p_none;
    logic [CYC_W-1:0] p_cycles;
    logic [2:0]       refmux_o;
    logic             sigmux_o, cmpr_latch_ctl_o, busy_o, done_o;
    logic [CYC_W-1:0] cycle_cnt_o;
    logic [7:0]       monitor_o;
`ifdef REFMUX_MOD_CMPR_COUNT_EN
    logic [CYC_W-1:0] cmpr_hi_cnt_o;
`endif

    typedef struct {
        logic [2:0]  refmux;
        logic        latch;
        logic        busy;
        logic        done;
        logic [15:0] cyc;
        logic [7:0]  mon;
        logic [7:0]  mask;
        logic [15:0] hi;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mon_mask = 8'hFF;
    logic [15:0] exp_hi   = 16'd0;

    always #5 clk = ~clk;

    refmux_modulator #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_i             (start_i),
        .abort_i             (abort_i),
        .mode3_i             (mode3_i),
        .p_clk_count_reset_i (p_reset),
        .p_clk_count_fix_i   (p_fix),
        .p_clk_count_none_i  (p_none),
        .p_cycles_i          (p_cycles),
        .cmpr_val_i          (cmpr_val_i),
        .refmux_o            (refmux_o),
        .sigmux_o            (sigmux_o),
        .cmpr_latch_ctl_o    (cmpr_latch_ctl_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .cycle_cnt_o         (cycle_cnt_o),
        .monitor_o           (monitor_o)
`ifdef REFMUX_MOD_CMPR_COUNT_EN
        ,
        .cmpr_hi_cnt_o       (cmpr_hi_cnt_o)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("refmux_o", 32'(refmux_o), 32'(e.refmux));
            chk("cmpr_latch_ctl_o", 32'(cmpr_latch_ctl_o), 32'(e.latch));
            chk("busy_o", 32'(busy_o), 32'(e.busy));
            chk("done_o", 32'(done_o), 32'(e.done));
            chk("cycle_cnt_o", 32'(cycle_cnt_o), 32'(e.cyc));
            chk("sigmux_o", 32'(sigmux_o), 32'd0);
            chk("monitor_o", 32'(monitor_o & e.mask), 32'(e.mon & e.mask));
`ifdef REFMUX_MOD_CMPR_COUNT_EN
            chk("cmpr_hi_cnt_o", 32'(cmpr_hi_cnt_o), 32'(e.hi));
`endif
        end
    end

    task automatic push(input logic [2:0] r, input logic l, input logic b, input logic d,
                        input int cyc, input logic [7:0] mon);
        exp_t e;
        @(posedge clk);
        #1;
        e.refmux = r;
        e.latch  = l;
        e.busy   = b;
        e.done   = d;
        e.cyc    = 16'(cyc);
        e.mon    = mon;
        e.mask   = mon_mask;
        e.hi     = exp_hi;
        sb.push_back(e);
    endtask

    // One busy phase of n clocks driving code r.
    task automatic ph(input logic [2:0] r, input int n, input int cyc);
        for (int i = 0; i < n; i++)
            push(r, r == R_RESET, 1'b1, 1'b0, cyc,
                 {3'b000, 1'b1, 1'b0, r == R_NONE, r == R_NEG, r == R_POS});
    endtask

    task automatic idle(input int n, input int cyc);
        for (int i = 0; i < n; i++) push(R_RESET, 1'b1, 1'b0, 1'b0, cyc, 8'h00);
    endtask

    task automatic done_st(input int n, input int cyc);
        for (int i = 0; i < n; i++) push(R_RESET, 1'b1, 1'b0, 1'b1, cyc, 8'h20);
    endtask

    task automatic setp(input int r, input int f, input int nn, input int c, input logic m3);
        p_reset  = CNT_W'(r);
        p_fix    = CNT_W'(f);
        p_none   = CNT_W'(nn);
        p_cycles = CYC_W'(c);
        mode3_i  = m3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; cmpr_val_i = 1'b0;
        setp(0, 0, 0, 0, 1'b0);
        idle(2, 0);
        reset = 1'b0;

        // 1: two-phase, reset=4 fix=3 cycles=2
        setp(4, 3, 0, 2, 1'b0);
        start_i = 1'b1; ph(R_RESET, 1, 0); start_i = 1'b0;
        ph(R_RESET, 4, 0);
        ph(R_POS, 4, 0); ph(R_NEG, 4, 0);
        ph(R_POS, 4, 1); ph(R_NEG, 4, 1);
        done_st(2, 2);

        // 2: three-phase, fix=1 none=2 cycles=1
        setp(0, 1, 2, 1, 1'b1);
        start_i = 1'b1; ph(R_RESET, 1, 0); start_i = 1'b0;
        ph(R_POS, 2, 0); ph(R_NEG, 2, 0); ph(R_NONE, 3, 0);
        done_st(2, 1);

        // 3: run forever with single-clock phases, then abort
        setp(0, 0, 0, 0, 1'b0);
        start_i = 1'b1; ph(R_RESET, 1, 0); start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ph(R_POS, 1, k); ph(R_NEG, 1, k);
        end
        ph(R_POS, 1, 5);
        abort_i = 1'b1; idle(1, 5); abort_i = 1'b0;
        idle(2, 5);

        // 4: start while busy is ignored; start+abort together aborts
        setp(1, 1, 0, 1, 1'b0);
        start_i = 1'b1; ph(R_RESET, 1, 0); start_i = 1'b0;
        ph(R_RESET, 1, 0);
        ph(R_POS, 1, 0);
        start_i = 1'b1; p_fix = CNT_W'(3);
        ph(R_POS, 1, 0);
        start_i = 1'b0;
        ph(R_NEG, 2, 0);
        done_st(1, 1);
        start_i = 1'b1; abort_i = 1'b1; idle(1, 1);
        start_i = 1'b0; abort_i = 1'b0; idle(1, 1);

        // 5: reset during FIX_NEG, then a normal run
        setp(0, 3, 0, 0, 1'b0);
        start_i = 1'b1; ph(R_RESET, 1, 0); start_i = 1'b0;
        ph(R_POS, 4, 0); ph(R_NEG, 4, 0);
        ph(R_POS, 4, 1); ph(R_NEG, 1, 1);
        reset = 1'b1; idle(1, 0); reset = 1'b0;
        setp(2, 0, 0, 1, 1'b0);
        start_i = 1'b1; ph(R_RESET, 1, 0); start_i = 1'b0;
        ph(R_RESET, 2, 0); ph(R_POS, 1, 0); ph(R_NEG, 1, 0);
        done_st(2, 1);

`ifdef REFMUX_MOD_CMPR_COUNT_EN
        // 6: comparator high only at the last clock of the 2nd NEG phase (after sync)
        mon_mask = 8'hB7;
        setp(0, 1, 0, 3, 1'b0);
        start_i = 1'b1; ph(R_RESET, 1, 0); start_i = 1'b0;
        ph(R_POS, 2, 0); ph(R_NEG, 2, 0);
        ph(R_POS, 1, 1);
        cmpr_val_i = 1'b1;
        ph(R_POS, 1, 1); ph(R_NEG, 1, 1); ph(R_NEG, 1, 1);
        cmpr_val_i = 1'b0;
        exp_hi = 16'd1;
        ph(R_POS, 2, 2); ph(R_NEG, 2, 2);
        done_st(2, 3);
`endif

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
